// File: rtl/instr_fetch_buffer_pkg.sv
// Shared types for the instruction fetch buffer: FSM state encoding and queue entry layout.
package instr_fetch_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  localparam int ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] pcn;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_buffer_ifb_fifo.sv
// DEPTH x ENTRY_W synchronous FIFO, register storage with combinational head read.
module instr_fetch_buffer_ifb_fifo
  import instr_fetch_buffer_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic [CNT_W-1:0]   count
);

  logic [ENTRY_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               empty;
  logic               full;
  logic               pop_eff;
  logic               push_eff;
  logic [DEPTH-1:0]   we;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign pop_eff  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_eff = push && (!full || pop_eff);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_we
      assign we[gi] = push_eff && !clear && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we[i]) mem_reg[i] <= din;
      end
      if (clear) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push_eff) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        count_reg <= count_reg + CNT_W'(push_eff) - CNT_W'(pop_eff);
      end
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch front end: sequential prefetch from a req/ack instruction memory into a
// small queue feeding IF/ID; redirects flush the queue and discard in-flight fetches.
module instr_fetch_buffer
  import instr_fetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  localparam int         CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [31:0]      imem_data_i,
  output logic             out_valid_o,
  output logic [31:0]      out_pc_o,
  output logic [31:0]      out_instr_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] level_o
);

  fetch_state_e     state_reg;
  logic [31:0]      fpc_reg;
  logic             req_reg;
  logic [31:0]      addr_reg;

  logic [CNT_W-1:0] count;
  logic             has_room;
  logic             push;
  logic             pop;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  fetch_entry_t     head;

  // Only issued from IDLE, where nothing is in flight, so registered count alone decides.
  assign has_room = (count < CNT_W'(DEPTH));
  assign push     = (state_reg == ST_REQ) && imem_ack_i && !redirect_i;
  assign pop      = out_valid_o && out_ready_i && !redirect_i;
  assign fifo_din = {fpc_reg + 32'd4, imem_data_i};

  instr_fetch_buffer_ifb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i(clk_i),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .clear(redirect_i),
    .din  (fifo_din),
    .dout (fifo_dout),
    .count(count)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      fpc_reg   <= RESET_PC;
      req_reg   <= 1'b0;
      addr_reg  <= 32'h0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (redirect_i) begin
            fpc_reg   <= redirect_pc_i;
            addr_reg  <= redirect_pc_i;
            req_reg   <= 1'b1;
            state_reg <= ST_REQ;
          end else if (has_room) begin
            addr_reg  <= fpc_reg;
            req_reg   <= 1'b1;
            state_reg <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (imem_ack_i && !redirect_i) begin
            fpc_reg   <= fpc_reg + 32'd4;
            req_reg   <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (imem_ack_i) begin
            // Redirect coincides with the ack: drop the data, fetch the new target right away.
            fpc_reg   <= redirect_pc_i;
            addr_reg  <= redirect_pc_i;
            req_reg   <= 1'b1;
            state_reg <= ST_REQ;
          end else if (redirect_i) begin
            fpc_reg   <= redirect_pc_i;
            state_reg <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (imem_ack_i) begin
            fpc_reg   <= redirect_i ? redirect_pc_i : fpc_reg;
            addr_reg  <= redirect_i ? redirect_pc_i : fpc_reg;
            req_reg   <= 1'b1;
            state_reg <= ST_REQ;
          end else if (redirect_i) begin
            fpc_reg <= redirect_pc_i;
          end
        end
        default: begin
          req_reg   <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign head        = fetch_entry_t'(fifo_dout);
  assign imem_req_o  = req_reg;
  assign imem_addr_o = addr_reg;
  assign out_valid_o = (count != '0);
  assign out_pc_o    = head.pcn;
  assign out_instr_o = head.instr;
  assign level_o     = count;

endmodule
